// File: rtl/sine_period_meter_if.sv
// Sample-stream and measurement-result bundle for sine_period_meter.
// The slave modport is the meter. The master modport is the sample source or observer.
interface sine_period_meter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [CNT_W-1:0]  period;
  logic [DATA_W-1:0] peak;
  logic [DATA_W-1:0] trough;
  logic              result_valid;
  logic              locked;
  logic              overflow;

  modport master (
    output sample_valid, sample,
    input  period, peak, trough, result_valid, locked, overflow
  );

  modport slave (
    input  sample_valid, sample,
    output period, peak, trough, result_valid, locked, overflow
  );
endinterface

// File: rtl/sine_period_meter.sv
// Measures the period, peak and trough of an offset-binary sine stream.
// Rising midscale crossings are detected with hysteresis.
module sine_period_meter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned HYST   = 4
) (
  input logic             clk,
  input logic             rst,
  sine_period_meter_if.slave bus
);

  localparam int unsigned MID = 1 << (DATA_W - 1);
  localparam logic [DATA_W:0]  RISE_TH = (DATA_W + 1)'(MID + HYST);
  localparam logic [DATA_W:0]  ARM_TH  = (DATA_W + 1)'(MID - HYST);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {SEARCH, MEASURE} state_t;

  state_t            state;
  logic              arm;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] pk;
  logic [DATA_W-1:0] tr;
  logic [CNT_W-1:0]  period_q;
  logic [DATA_W-1:0] peak_q;
  logic [DATA_W-1:0] trough_q;
  logic              result_valid_q;
  logic              locked_q;
  logic              overflow_q;

  logic [DATA_W:0] sample_ext_c;
  logic            rise_c;
  logic            low_c;
  logic            cross_c;

  // Threshold compares run one bit wider, so MID+HYST cannot wrap.
  always_comb begin
    sample_ext_c = {1'b0, bus.sample};
    rise_c       = (sample_ext_c >= RISE_TH);
    low_c        = (sample_ext_c < ARM_TH);
    cross_c      = rise_c & arm;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= SEARCH;
      arm            <= 1'b0;
      cnt            <= '0;
      pk             <= '0;
      tr             <= '0;
      period_q       <= '0;
      peak_q         <= '0;
      trough_q       <= '0;
      result_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (bus.sample_valid) begin
        if (low_c)   arm <= 1'b1;
        if (cross_c) arm <= 1'b0;
        case (state)
          SEARCH: begin
            if (cross_c) begin
              state <= MEASURE;
              cnt   <= CNT_W'(1);
              pk    <= bus.sample;
              tr    <= bus.sample;
            end
          end
          MEASURE: begin
            if (cross_c) begin
              // A crossing closes the current period and opens the next one.
              period_q       <= cnt;
              peak_q         <= pk;
              trough_q       <= tr;
              result_valid_q <= 1'b1;
              locked_q       <= 1'b1;
              overflow_q     <= 1'b0;
              cnt            <= CNT_W'(1);
              pk             <= bus.sample;
              tr             <= bus.sample;
            end else if (cnt == CNT_MAX) begin
              // The counter is saturated: drop lock and search again from a fresh arm.
              overflow_q <= 1'b1;
              locked_q   <= 1'b0;
              arm        <= 1'b0;
              state      <= SEARCH;
            end else begin
              cnt <= cnt + CNT_W'(1);
              if (bus.sample > pk) pk <= bus.sample;
              if (bus.sample < tr) tr <= bus.sample;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.peak         = peak_q;
  assign bus.trough       = trough_q;
  assign bus.result_valid = result_valid_q;
  assign bus.locked       = locked_q;
  assign bus.overflow     = overflow_q;

endmodule
